operand_issue: RTL and testbench

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/my_pkg.sv | 21 ++
 rtl/issue_fifo.sv | 65 ++++++
 rtl/operand_issue.sv | 139 +++++++++++++
 tb/tb_operand_issue.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : my_pkg
//  Description : Shared types and constants for the operand issue stage:
//                logic-unit operation encoding and default FIFO depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package my_pkg;

    // Logic-unit operation: OP0 = XOR, OP1 = OR, OP2 = AND
    typedef enum logic [1:0] {
        OP0 = 2'd0,
        OP1 = 2'd1,
        OP2 = 2'd2
    } instruction_type;

    // Default number of buffered requests ahead of the issue registers
    localparam int ISSUE_DEPTH_DEFAULT = 4;

endpackage : my_pkg
`default_nettype wire

// File: rtl/issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : issue_fifo
//  Description : Circular request buffer for operand_issue. Wrapping read and
//                write pointers plus an occupancy count one bit wider than the
//                pointers, so full and empty are both distinguishable.
//                DEPTH must be a power of two and at least 2 so the pointers
//                wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_fifo
    import my_pkg::*;
#(
    parameter  int DEPTH = ISSUE_DEPTH_DEFAULT,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Storage array: data only, no reset needed since count gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rptr];
    assign count = r_count;

endmodule : issue_fifo
`default_nettype wire

// File: rtl/operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : operand_issue
//  Description : Buffers logic-unit requests in issue_fifo and presents them
//                through registered issue outputs that feed the logic unit
//                directly. A registered result tag follows each consumed
//                request so it lines up with the logic unit's registered
//                result.
//                Optional build macro ISSUE_BYPASS_EN: when the FIFO is empty
//                and the issue stage can accept, a new request is written
//                straight into the issue registers, saving one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_issue
    import my_pkg::*;
#(
    parameter int DEPTH = ISSUE_DEPTH_DEFAULT,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_opA,
    input  logic [31:0]      in_opB,
    input  instruction_type  in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             stall,
    output logic [31:0]      issue_opA,
    output logic [31:0]      issue_opB,
    output instruction_type  issue_op,
    output logic             issue_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_tag_valid
);

    // Entry layout: {tag, op, opB, opA}
    localparam int c_ENT_W = 64 + 2 + TAG_W;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [c_ENT_W-1:0] w_in_entry;
    logic [c_ENT_W-1:0] w_head;
    logic [c_ENT_W-1:0] w_load_entry;
    logic [c_CNT_W-1:0] w_count;
    logic               w_accept;
    logic               w_fifo_empty;
    logic               w_consume;
    logic               w_can_load;
    logic               w_bypass;
    logic               w_fifo_push;
    logic               w_pop;
    logic               w_load;

    logic [31:0]        r_issue_opA;
    logic [31:0]        r_issue_opB;
    instruction_type    r_issue_op;
    logic [TAG_W-1:0]   r_issue_tag;
    logic               r_issue_valid;
    logic [TAG_W-1:0]   r_res_tag;
    logic               r_res_tag_valid;

    // Ready depends only on registered occupancy, never on in_valid
    assign in_ready     = (w_count != c_CNT_W'(DEPTH));
    assign w_accept     = in_valid && in_ready;
    assign w_fifo_empty = (w_count == '0);
    assign w_in_entry   = {in_tag, in_op, in_opB, in_opA};

    // The issue slot drains when downstream is not stalled; it can be
    // refilled when it is empty or draining this cycle.
    assign w_consume    = r_issue_valid && !stall;
    assign w_can_load   = !r_issue_valid || w_consume;

`ifdef ISSUE_BYPASS_EN
    // Empty FIFO and a free issue slot: skip the FIFO for this request
    assign w_bypass     = w_accept && w_fifo_empty && w_can_load;
`else
    assign w_bypass     = 1'b0;
`endif

    // Bypass only fires with an empty FIFO, so it never overlaps a pop
    assign w_fifo_push  = w_accept && !w_bypass;
    assign w_pop        = w_can_load && !w_fifo_empty;
    assign w_load       = w_pop || w_bypass;
    assign w_load_entry = w_bypass ? w_in_entry : w_head;

    issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_fifo_push),
        .push_data (w_in_entry),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    // Issue registers: load from FIFO head (or bypass), clear valid on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_opA   <= '0;
            r_issue_opB   <= '0;
            r_issue_op    <= OP0;
            r_issue_tag   <= '0;
            r_issue_valid <= 1'b0;
        end else if (w_load) begin
            r_issue_opA   <= w_load_entry[31:0];
            r_issue_opB   <= w_load_entry[63:32];
            r_issue_op    <= instruction_type'(w_load_entry[65:64]);
            r_issue_tag   <= w_load_entry[c_ENT_W-1:66];
            r_issue_valid <= 1'b1;
        end else if (w_consume) begin
            r_issue_valid <= 1'b0;
        end
    end

    // Result tag trails the consumed request by one edge, matching result_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_tag       <= '0;
            r_res_tag_valid <= 1'b0;
        end else begin
            r_res_tag_valid <= w_consume;
            if (w_consume) begin
                r_res_tag <= r_issue_tag;
            end
        end
    end

    assign issue_opA     = r_issue_opA;
    assign issue_opB     = r_issue_opB;
    assign issue_op      = r_issue_op;
    assign issue_valid   = r_issue_valid;
    assign res_tag       = r_res_tag;
    assign res_tag_valid = r_res_tag_valid;

endmodule : operand_issue
`default_nettype wire

// File: tb/tb_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_issue
//  Description : Directed self-checking bench for operand_issue with a small
//                reference queue of accepted requests and a bench-side logic
//                unit that registers the result of each consumed request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_issue;
    import my_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
`ifdef ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        instruction_type  op;
        logic [TAG_W-1:0] tag;
    } ent_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_opA;
    logic [31:0]      in_opB;
    instruction_type  in_op;
    logic [TAG_W-1:0] in_tag;
    logic             stall;
    logic [31:0]      issue_opA;
    logic [31:0]      issue_opB;
    instruction_type  issue_op;
    logic             issue_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_tag_valid;

    int               checks   = 0;
    int               failures = 0;
    int               n_res    = 0;
    ent_t             q[$];
    bit               res_pend = 1'b0;
    logic [TAG_W-1:0] res_exp_tag;
    logic [31:0]      res_exp_val;
    logic [31:0]      r_result;

    operand_issue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opA        (in_opA),
        .in_opB        (in_opB),
        .in_op         (in_op),
        .in_tag        (in_tag),
        .stall         (stall),
        .issue_opA     (issue_opA),
        .issue_opB     (issue_opB),
        .issue_op      (issue_op),
        .issue_valid   (issue_valid),
        .res_tag       (res_tag),
        .res_tag_valid (res_tag_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lu(input logic [31:0] a, input logic [31:0] b,
                                       input instruction_type op);
        case (op)
            OP0:     return a ^ b;
            OP1:     return a | b;
            OP2:     return a & b;
            default: return 32'h0;
        endcase
    endfunction

    // Bench-side logic unit: registered result of each consumed request
    always @(posedge clk) begin
        if (issue_valid && !stall) r_result <= lu(issue_opA, issue_opB, issue_op);
    end

    // Monitor: issue regs must show the oldest outstanding request; each
    // consumed request must produce exactly one tagged result next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            res_pend = 1'b0;
        end else begin
            if (res_pend) begin
                check("res_valid", 64'(res_tag_valid), 64'd1);
                check("res_tag", 64'(res_tag), 64'(res_exp_tag));
                check("result", 64'(r_result), 64'(res_exp_val));
                n_res++;
            end else begin
                check("res_idle", 64'(res_tag_valid), 64'd0);
            end
            res_pend = 1'b0;
            if (issue_valid) begin
                if (q.size() == 0) begin
                    check("issue_spurious", 64'(issue_valid), 64'd0);
                end else begin
                    check("issue_opA", 64'(issue_opA), 64'(q[0].a));
                    check("issue_opB", 64'(issue_opB), 64'(q[0].b));
                    check("issue_op", 64'(issue_op), 64'(q[0].op));
                    if (!stall) begin
                        res_pend    = 1'b1;
                        res_exp_tag = q[0].tag;
                        res_exp_val = lu(q[0].a, q[0].b, q[0].op);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request (called at posedge+1) and hold it until accepted
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input instruction_type op, input logic [TAG_W-1:0] tag);
        bit   acc = 1'b0;
        ent_t e;
        in_valid = 1'b1;
        in_opA   = a;
        in_opB   = b;
        in_op    = op;
        in_tag   = tag;
        for (int w = 0; w < 100 && !acc; w++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        if (acc) begin
            e.a = a; e.b = b; e.op = op; e.tag = tag;
            q.push_back(e);
        end else begin
            check("send_timeout", 64'(in_ready), 64'd1);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 200 && (q.size() != 0 || res_pend); w++) @(posedge clk);
        check("drain", 64'(q.size()), 64'd0);
        #1;
    endtask

    initial begin
        int base;
        bit done;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_opA   = '0;
        in_opB   = '0;
        in_op    = OP0;
        in_tag   = '0;
        stall    = 1'b0;

        // Reset state
        tick(3);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_res_valid", 64'(res_tag_valid), 64'd0);
        check("rst_issue_opA", 64'(issue_opA), 64'd0);
        check("rst_issue_op", 64'(issue_op), 64'(OP0));
        check("rst_res_tag", 64'(res_tag), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Single request latency and XOR result
        send(32'hF0F0F0F0, 32'h0FF00FF0, OP0, 4'd3);
        @(negedge clk);
        check("lat_iv_n", 64'(issue_valid), 64'(BYP));
        check("lat_rv_n", 64'(res_tag_valid), 64'd0);
        @(negedge clk);
        check("lat_iv_n1", 64'(issue_valid), 64'(!BYP));
        check("lat_rv_n1", 64'(res_tag_valid), 64'(BYP));
        @(negedge clk);
        check("lat_rv_n2", 64'(res_tag_valid), 64'(!BYP));
        check("lat_tag", 64'(res_tag), 64'd3);
        check("lat_result", 64'(r_result), 64'hFF00FF00);
        tick(1);
        drain();

        // Back-to-back with stall held: ready drops after the 5th accept
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(32'h1000 + 32'(i), 32'h00FF00FF, OP1, TAG_W'(i));
            if (i == 3) check("b2b_ready_4", 64'(in_ready), 64'd1);
        end
        check("b2b_ready_5", 64'(in_ready), 64'd0);
        fork
            send(32'h1005, 32'h00FF00FF, OP1, TAG_W'(5));
            begin
                tick(2);
                check("b2b_ready_held", 64'(in_ready), 64'd0);
                stall = 1'b0;
                base  = n_res;
                tick(6);
                @(negedge clk);
                #1;
                check("b2b_pulses_6cyc", 64'(n_res - base), 64'd6);
            end
        join
        tick(1);
        drain();

        // Stall toggling every other cycle with random requests
        base = n_res;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send($urandom, $urandom, instruction_type'($urandom_range(0, 2)), TAG_W'(i));
                end
                done = 1'b1;
            end
            begin
                for (int c = 0; c < 400 && !done; c++) begin
                    tick(1);
                    if (c % 2 == 0) stall = ~stall;
                end
            end
        join
        stall = 1'b0;
        drain();
        check("toggle_pulses", 64'(n_res - base), 64'd10);

        // Reset with requests buffered
        stall = 1'b1;
        send(32'hAAAA0000, 32'h5555FFFF, OP2, 4'd7);
        send(32'hAAAA0001, 32'h5555FFFF, OP1, 4'd8);
        send(32'hAAAA0002, 32'h5555FFFF, OP2, 4'd9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_issue_valid", 64'(issue_valid), 64'd0);
        check("mid_rst_issue_op", 64'(issue_op), 64'(OP0));
        check("mid_rst_issue_opA", 64'(issue_opA), 64'd0);
        tick(2);
        rst_n = 1'b1;
        stall = 1'b0;
        base  = n_res;
        tick(6);
        check("post_rst_no_res", 64'(n_res - base), 64'd0);
        check("post_rst_issue_valid", 64'(issue_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Simultaneous push and pop at count = DEPTH-1
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h20 + 32'(i), 32'hFFFF0000, OP2, TAG_W'(i));
        end
        check("pp_fill_count", 64'(u_dut.w_count), 64'(DEPTH - 1));
        stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(32'h40 + 32'(i), 32'h0F0F0F0F, OP0, TAG_W'(i + 4));
            check("pp_count", 64'(u_dut.w_count), 64'(DEPTH - 1));
            check("pp_ready", 64'(in_ready), 64'd1);
        end
        drain();
        check("pp_end_empty", 64'(u_dut.w_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_operand_issue
`default_nettype wire
